game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 500000: clk cycles per game tick.
REQ-002 Parameter GROUND_Y, default 400: duck resting row.
REQ-003 Parameter JUMP_H, default 100: jump apex height above GROUND_Y, in rows.
REQ-004 Parameter STEP, default 4: rows or columns moved per tick.
REQ-005 Parameter SPAWN_X, default 784; parameter LEFT_X, default 144.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 btn_start  in  1  start/restart request; level, already synchronous to clk.
REQ-009 btn_jump  in  1  jump request; level, synchronous.
REQ-010 btn_duck  in  1  crouch request; level, synchronous.
REQ-011 collision  in  1  duck/obstacle pixel overlap flag from the draw path.
REQ-012 state  out  2  00 IDLE, 01 RUN, 10 OVER.
REQ-013 duck_y  out  10  duck top row.
REQ-014 duck_crouch  out  1  crouch pose active.
REQ-015 obst_valid  out  1  obstacle on screen.
REQ-016 obst_x  out  10  obstacle left column.
REQ-017 obst_type  out  1  0 = ground obstacle, 1 = flying obstacle.
REQ-018 score  out  16  obstacles cleared in the current/last run.

Function
REQ-019 Rising edge of a button = current level AND NOT the value registered on the previous clk; one register per button.
REQ-020 Tick counter: counts 0..TICK_DIV-1 in RUN only; tick is a one-clk pulse at TICK_DIV-1, then the counter wraps to 0; the counter is held at 0 outside RUN.
REQ-021 FSM: IDLE -> RUN on btn_start rise; RUN -> OVER when collision=1 and obst_valid=1; OVER -> IDLE on btn_start rise; no other transitions.
REQ-022 On IDLE->RUN: score=0, duck_y=GROUND_Y, obst_valid=0, jump phase=GROUND, tick counter=0, all in the same clk.
REQ-023 Jump phases GROUND/UP/DOWN: GROUND->UP on btn_jump rise in RUN with duck_crouch=0; jump requests while in UP or DOWN are ignored.
REQ-024 UP: each tick duck_y -= STEP; when the new value is at or below GROUND_Y-JUMP_H, clamp to GROUND_Y-JUMP_H and enter DOWN.
REQ-025 DOWN: each tick duck_y += STEP; when the new value is at or above GROUND_Y, clamp to GROUND_Y and enter GROUND.
REQ-026 duck_crouch = btn_duck registered each clk while in RUN and phase GROUND; forced 0 in air and outside RUN.
REQ-027 8-bit LFSR, taps 8,6,5,4, seed 8'hA5, advances every clk in every state; it is never all-zero.
REQ-028 Spawn: on a tick with obst_valid=0, set obst_valid=1, obst_x=SPAWN_X, obst_type=lfsr[0].
REQ-029 Move: on a tick with obst_valid=1, if obst_x < LEFT_X+STEP then obst_valid=0 and score+1; otherwise obst_x -= STEP. Spawn and retire never occur on the same tick.
REQ-030 Score saturates at 16'hFFFF.
REQ-031 Collision and retire in the same clk: collision wins; go to OVER and leave score unchanged.
REQ-032 collision is ignored when obst_valid=0 or state is not RUN.
REQ-033 In OVER, duck_y, duck_crouch, obst_x, obst_valid, obst_type and score hold their values.
REQ-034 In IDLE, duck_y=GROUND_Y, obst_valid=0; score holds the last run's value.
REQ-035 All outputs are registered; FSM responses take effect one clk after the triggering edge or tick.

Reset
REQ-036 rst_n=0 at a clk edge: state=IDLE, duck_y=GROUND_Y, duck_crouch=0, obst_valid=0, obst_x=SPAWN_X, obst_type=0, score=0, tick counter=0, LFSR=8'hA5, button history=0.
REQ-037 Reset asserted mid-jump or in OVER has the same effect; the first button rise is detected only after rst_n=1 and a clk with that button at 0.

Verification (TICK_DIV=4, STEP=4, JUMP_H=8)
REQ-038 Reset, then btn_start pulse -> state=01, score=0, duck_y=400; first spawn 4 clks later with obst_x=784.
REQ-039 btn_jump rise in RUN -> duck_y sequence 396, 392, 396, 400 on successive ticks; a second rise mid-air leaves the sequence unchanged.
REQ-040 No collision for 161 ticks after spawn -> obst_valid falls at obst_x=144, score=1, respawn on the next tick.
REQ-041 collision=1 on the same clk as retire -> state=10, score unchanged, obst_x frozen; btn_start -> 00 with score held; next btn_start -> score=0.
REQ-042 Hold btn_start high across reset release -> stays IDLE until btn_start drops and rises again.
REQ-043 Force score=16'hFFFF via a run, then clear one more obstacle -> score stays 16'hFFFF.

Source files
------------

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Game-state sequencer for a side-scrolling "duck and jump" game. It runs a
// three-state game FSM (IDLE / RUN / OVER), divides clk into game ticks,
// animates the duck's jump arc and crouch pose, and spawns, scrolls and
// retires one obstacle at a time, counting cleared obstacles as the score.
//
// Ports
//   clk          in   single clock for all logic
//   rst_n        in   synchronous, active-low reset
//   btn_start    in   start / restart request (level, clk-synchronous)
//   btn_jump     in   jump request (level, clk-synchronous)
//   btn_duck     in   crouch request (level, clk-synchronous)
//   collision    in   duck/obstacle pixel overlap from the draw path
//   state        out  2'b00 IDLE, 2'b01 RUN, 2'b10 OVER
//   duck_y       out  duck top row
//   duck_crouch  out  crouch pose active
//   obst_valid   out  obstacle on screen
//   obst_x       out  obstacle left column
//   obst_type    out  0 ground obstacle, 1 flying obstacle
//   score        out  obstacles cleared in the current / last run
// ---------------------------------------------------------------------------
module game_sequencer #(
   parameter int unsigned TICK_DIV = 500000,
   parameter int unsigned GROUND_Y = 400,
   parameter int unsigned JUMP_H   = 100,
   parameter int unsigned STEP     = 4,
   parameter int unsigned SPAWN_X  = 784,
   parameter int unsigned LEFT_X   = 144
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_start,
   input  logic        btn_jump,
   input  logic        btn_duck,
   input  logic        collision,
   output logic [1:0]  state,
   output logic [9:0]  duck_y,
   output logic        duck_crouch,
   output logic        obst_valid,
   output logic [9:0]  obst_x,
   output logic        obst_type,
   output logic [15:0] score
);

   localparam int unsigned     CNT_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [9:0]      GROUND_ROW   = 10'(GROUND_Y);
   localparam logic [9:0]      APEX_ROW     = 10'(GROUND_Y - JUMP_H);
   localparam logic [9:0]      STEP_10      = 10'(STEP);
   localparam logic [9:0]      SPAWN_COL    = 10'(SPAWN_X);
   // Rising: a step from any row at or below UP_LIMIT lands at or past the apex.
   localparam logic [10:0]     UP_LIMIT     = 11'(GROUND_Y - JUMP_H + STEP);
   localparam logic [10:0]     GROUND_11    = 11'(GROUND_Y);
   localparam logic [10:0]     STEP_11      = 11'(STEP);
   localparam logic [10:0]     RETIRE_BELOW = 11'(LEFT_X + STEP);
   localparam logic [15:0]     SCORE_MAX    = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_OVER = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      PH_GROUND = 2'b00,
      PH_UP     = 2'b01,
      PH_DOWN   = 2'b10
   } phase_t;

   state_t             st_q, st_n;
   phase_t             ph_q, ph_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [7:0]         lfsr_q;
   // Per-button "previous level was low" flag, i.e. the inverted history bit.
   // Clearing it at reset means a button held through reset release must be
   // seen low for one clk before its next rise counts.
   logic               start_armed_q, jump_armed_q;
   logic               start_rise, jump_rise;
   logic               tick, hit;

   logic [9:0]         y_n, x_n;
   logic               crouch_n, valid_n, type_n;
   logic [15:0]        score_n;

   assign start_rise = btn_start & start_armed_q;
   assign jump_rise  = btn_jump  & jump_armed_q;
   assign tick       = (st_q == S_RUN) && (cnt_q == TICK_LAST);
   assign hit        = collision & obst_valid;
   assign state      = st_q;

   // -----------------------------------------------------------------------
   // Next-state / next-output logic
   // -----------------------------------------------------------------------
   always_comb begin
      st_n     = st_q;
      ph_n     = ph_q;
      cnt_n    = '0;
      y_n      = duck_y;
      crouch_n = duck_crouch;
      valid_n  = obst_valid;
      x_n      = obst_x;
      type_n   = obst_type;
      score_n  = score;

      case (st_q)
         S_IDLE: begin
            y_n      = GROUND_ROW;
            valid_n  = 1'b0;
            crouch_n = 1'b0;
            ph_n     = PH_GROUND;
            if (start_rise) begin
               st_n    = S_RUN;
               score_n = '0;
            end
         end

         S_RUN: begin
            if (hit) begin
               // Collision freezes the scene in the clk it is seen, even if an
               // obstacle would otherwise retire and score in that same clk.
               st_n = S_OVER;
            end else begin
               cnt_n = tick ? '0 : cnt_q + CNT_W'(1);

               case (ph_q)
                  PH_GROUND: begin
                     if (jump_rise && !duck_crouch) ph_n = PH_UP;
                  end
                  PH_UP: begin
                     if (tick) begin
                        if ({1'b0, duck_y} <= UP_LIMIT) begin
                           y_n  = APEX_ROW;
                           ph_n = PH_DOWN;
                        end else begin
                           y_n = duck_y - STEP_10;
                        end
                     end
                  end
                  PH_DOWN: begin
                     if (tick) begin
                        if (({1'b0, duck_y} + STEP_11) >= GROUND_11) begin
                           y_n  = GROUND_ROW;
                           ph_n = PH_GROUND;
                        end else begin
                           y_n = duck_y + STEP_10;
                        end
                     end
                  end
                  default: ph_n = PH_GROUND;
               endcase

               // Crouch follows the phase the duck ends up in this clk, so a
               // jump launched now never shows a crouched pose in the air.
               crouch_n = (ph_n == PH_GROUND) && btn_duck;

               if (tick) begin
                  if (!obst_valid) begin
                     valid_n = 1'b1;
                     x_n     = SPAWN_COL;
                     type_n  = lfsr_q[0];
                  end else if ({1'b0, obst_x} < RETIRE_BELOW) begin
                     valid_n = 1'b0;
                     if (score != SCORE_MAX) score_n = score + 16'd1;
                  end else begin
                     x_n = obst_x - STEP_10;
                  end
               end
            end
         end

         S_OVER: begin
            if (start_rise) begin
               st_n     = S_IDLE;
               y_n      = GROUND_ROW;
               valid_n  = 1'b0;
               crouch_n = 1'b0;
               ph_n     = PH_GROUND;
            end
         end

         default: st_n = S_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // State and output registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q          <= S_IDLE;
         ph_q          <= PH_GROUND;
         cnt_q         <= '0;
         lfsr_q        <= 8'hA5;
         start_armed_q <= 1'b0;
         jump_armed_q  <= 1'b0;
         duck_y        <= GROUND_ROW;
         duck_crouch   <= 1'b0;
         obst_valid    <= 1'b0;
         obst_x        <= SPAWN_COL;
         obst_type     <= 1'b0;
         score         <= '0;
      end else begin
         st_q          <= st_n;
         ph_q          <= ph_n;
         cnt_q         <= cnt_n;
         // x^8 + x^6 + x^5 + x^4 + 1, maximal length, free-running
         lfsr_q        <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         start_armed_q <= ~btn_start;
         jump_armed_q  <= ~btn_jump;
         duck_y        <= y_n;
         duck_crouch   <= crouch_n;
         obst_valid    <= valid_n;
         obst_x        <= x_n;
         obst_type     <= type_n;
         score         <= score_n;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//
// Self-checking bench for game_sequencer with a small geometry (TICK_DIV=4,
// STEP=4, JUMP_H=8). A behavioural game model in plain integers is stepped
// alongside the DUT once per clk; every output is compared after each edge.
// Directed phases cover reset with start held, first spawn latency, the jump
// arc, a full obstacle crossing, collision on the retire clk, restart, score
// saturation, and reset in mid-jump. Button/collision noise comes from
// $urandom.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

   localparam int TD = 4;
   localparam int GY = 400;
   localparam int JH = 8;
   localparam int ST = 4;
   localparam int SX = 784;
   localparam int LX = 144;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_start = 1'b0;
   logic        btn_jump = 1'b0;
   logic        btn_duck = 1'b0;
   logic        collision = 1'b0;
   logic [1:0]  state;
   logic [9:0]  duck_y;
   logic        duck_crouch;
   logic        obst_valid;
   logic [9:0]  obst_x;
   logic        obst_type;
   logic [15:0] score;

   game_sequencer #(
      .TICK_DIV(TD),
      .GROUND_Y(GY),
      .JUMP_H  (JH),
      .STEP    (ST),
      .SPAWN_X (SX),
      .LEFT_X  (LX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_start  (btn_start),
      .btn_jump   (btn_jump),
      .btn_duck   (btn_duck),
      .collision  (collision),
      .state      (state),
      .duck_y     (duck_y),
      .duck_crouch(duck_crouch),
      .obst_valid (obst_valid),
      .obst_x     (obst_x),
      .obst_type  (obst_type),
      .score      (score)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: state 0 IDLE / 1 RUN / 2 OVER; phase 0 ground / 1 up / 2 down
   int m_state, m_phase, m_cnt, m_y, m_x, m_score, m_lfsr;
   bit m_crouch, m_valid, m_type;
   bit m_lo_s, m_lo_j;        // button seen low since last clk (and since reset)
   bit r_dk;                  // random duck level carried between cycles

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int lfsr_adv(input int v);
      int fb;
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      return ((v << 1) & 255) | fb;
   endfunction

   task automatic model_step(input bit rs, input bit st, input bit jp, input bit dk, input bit col);
      bit rise_s, rise_j, tick;
      if (!rs) begin
         m_state = 0; m_phase = 0; m_cnt = 0; m_y = GY; m_crouch = 0;
         m_valid = 0; m_x = SX; m_type = 0; m_score = 0; m_lfsr = 8'hA5;
         m_lo_s = 0; m_lo_j = 0;
         return;
      end
      rise_s = st && m_lo_s;
      rise_j = jp && m_lo_j;
      tick   = (m_state == 1) && (m_cnt == TD - 1);
      case (m_state)
         0: begin
            m_cnt = 0; m_y = GY; m_valid = 0; m_crouch = 0; m_phase = 0;
            if (rise_s) begin m_state = 1; m_score = 0; end
         end
         1: begin
            if (col && m_valid) begin
               m_state = 2; m_cnt = 0;
            end else begin
               m_cnt = tick ? 0 : m_cnt + 1;
               if (m_phase == 0) begin
                  if (rise_j && !m_crouch) m_phase = 1;
               end else if (tick) begin
                  if (m_phase == 1) begin
                     m_y -= ST;
                     if (m_y <= GY - JH) begin m_y = GY - JH; m_phase = 2; end
                  end else begin
                     m_y += ST;
                     if (m_y >= GY) begin m_y = GY; m_phase = 0; end
                  end
               end
               m_crouch = (m_phase == 0) && dk;
               if (tick) begin
                  if (!m_valid) begin
                     m_valid = 1; m_x = SX; m_type = m_lfsr[0];
                  end else if (m_x < LX + ST) begin
                     m_valid = 0;
                     if (m_score < 65535) m_score++;
                  end else begin
                     m_x -= ST;
                  end
               end
            end
         end
         default: begin
            if (rise_s) begin
               m_state = 0; m_y = GY; m_valid = 0; m_crouch = 0; m_phase = 0;
            end
         end
      endcase
      m_lo_s = !st;
      m_lo_j = !jp;
      m_lfsr = lfsr_adv(m_lfsr);
   endtask

   // One clk: drive inputs (caller is at a negedge), step model, compare after edge.
   task automatic cyc(input bit rs, input bit st, input bit jp, input bit dk, input bit col);
      rst_n = rs; btn_start = st; btn_jump = jp; btn_duck = dk; collision = col;
      model_step(rs, st, jp, dk, col);
      @(posedge clk);
      #1;
      check_eq("state",       state,       m_state);
      check_eq("duck_y",      duck_y,      m_y);
      check_eq("duck_crouch", duck_crouch, m_crouch);
      check_eq("obst_valid",  obst_valid,  m_valid);
      check_eq("obst_x",      obst_x,      m_x);
      check_eq("obst_type",   obst_type,   m_type);
      check_eq("score",       score,       m_score);
      @(negedge clk);
   endtask

   // Random play cycle; collision only raised when the model says it must be ignored.
   task automatic rcyc(input bit st);
      bit jp, col;
      jp = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) r_dk = ~r_dk;
      col = (m_state != 1 || !m_valid) ? ($urandom_range(0, 2) == 0) : 1'b0;
      cyc(1, st, jp, r_dk, col);
   endtask

   initial begin
      int n;
      int pv;
      int saved;
      int retires;
      int ys[$];
      int jexp[4];
      bit done;

      jexp = '{396, 392, 396, 400};
      r_dk = 0;
      @(negedge clk);

      // Reset with start held high, then release still holding it.
      repeat (3) cyc(0, 1, 0, 0, 0);
      repeat (5) cyc(1, 1, 0, 0, 0);
      check_eq("start_held_stays_idle", state, 2'b00);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      check_eq("start_enters_run", state, 2'b01);
      check_eq("start_score_zero", score, 0);
      check_eq("start_duck_ground", duck_y, GY);

      // First spawn latency.
      n = 0;
      while (!obst_valid && n < 20) begin
         cyc(1, 0, 0, 0, 0);
         n++;
      end
      check_eq("first_spawn_latency", n, 4);
      check_eq("first_spawn_x", obst_x, SX);

      // Jump arc with repeated jump rises while airborne.
      cyc(1, 0, 1, 0, 0);
      ys.delete();
      pv = GY;
      for (int i = 0; i < 60; i++) begin
         cyc(1, 0, (i % 2 == 1), 0, 0);
         if (int'(duck_y) != pv) begin
            pv = duck_y;
            ys.push_back(pv);
            if (pv == GY) break;
         end
      end
      check_eq("jump_arc_len", ys.size(), 4);
      for (int i = 0; i < 4 && i < ys.size(); i++) check_eq("jump_arc_y", ys[i], jexp[i]);

      // Full crossing: retire at LEFT_X, score 1, respawn on the next tick.
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         pv = m_valid;
         rcyc(0);
         if (pv && !m_valid && m_state == 1) check_eq("retire_x", obst_x, LX);
         done = (m_score == 1) && m_valid;
      end
      check_eq("timeout_first_clear", done, 1);
      check_eq("score_after_clear", score, 1);
      check_eq("respawn_x", obst_x, SX);

      // Collision in the same clk as a retire.
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         done = (m_state == 1) && m_valid && (m_x < LX + ST) && (m_cnt == TD - 1);
         if (!done) rcyc(0);
      end
      check_eq("timeout_retire_window", done, 1);
      saved = m_score;
      cyc(1, 0, 0, 0, 1);
      check_eq("collide_retire_state", state, 2'b10);
      check_eq("collide_retire_score", score, saved);
      check_eq("collide_retire_x", obst_x, LX);
      repeat (10) rcyc(0);
      check_eq("over_x_frozen", obst_x, LX);
      cyc(1, 1, 0, 0, 0);
      check_eq("over_to_idle", state, 2'b00);
      check_eq("idle_score_held", score, saved);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      check_eq("restart_score_zero", score, 0);

      // Saturation: preload score just below the top right after a spawn.
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         done = (m_state == 1) && m_valid && (m_x == SX);
         if (!done) rcyc(0);
      end
      check_eq("timeout_sat_spawn", done, 1);
      force dut.score = 16'hFFFE;
      m_score = 65534;
      cyc(1, 0, 0, 0, 0);
      release dut.score;
      cyc(1, 0, 0, 0, 0);
      check_eq("sat_preload", score, 16'hFFFE);
      retires = 0;
      for (int i = 0; i < 4000 && retires < 2; i++) begin
         pv = m_valid;
         rcyc(0);
         if (pv && !m_valid && m_state == 1) retires++;
      end
      check_eq("timeout_sat_retires", retires, 2);
      check_eq("sat_score", score, 16'hFFFF);

      // Reset in mid-jump with buttons held.
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      repeat (6) cyc(1, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 1, 1, 0);
      check_eq("midjump_reset_state", state, 2'b00);
      check_eq("midjump_reset_y", duck_y, GY);
      check_eq("midjump_reset_score", score, 0);
      repeat (4) cyc(1, 1, 1, 0, 0);
      check_eq("post_reset_held_idle", state, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
